// File: rtl/pipeline_controller_if.sv
// Control bus between the pipeline controller and the 8-bit datapath:
// stage IRs and flags flow in, every enable/select/strobe flows out.
interface pipeline_controller_if;
   logic       n;
   logic       z;
   logic [7:0] d_ir;
   logic [7:0] rf_ir;
   logic [7:0] x_ir;
   logic [7:0] wb_ir;

   logic       pc_write;
   logic       count_write;
   logic [1:0] addr_sel;
   logic [3:0] stage_load;
   logic [3:0] noop_sel;
   logic       mem_read;
   logic       mem_write;
   logic       r1_sel;
   logic       regw_sel;
   logic       rf_write;
   logic       r1b;
   logic       r2b;
   logic       alu1;
   logic [1:0] alu2;
   logic [2:0] alu_op;
   logic       alu3;
   logic       flag_write;
   logic       halted;

   modport master (
      input  n, z, d_ir, rf_ir, x_ir, wb_ir,
      output pc_write, count_write, addr_sel, stage_load, noop_sel,
             mem_read, mem_write, r1_sel, regw_sel, rf_write,
             r1b, r2b, alu1, alu2, alu_op, alu3, flag_write, halted
   );

   modport slave (
      output n, z, d_ir, rf_ir, x_ir, wb_ir,
      input  pc_write, count_write, addr_sel, stage_load, noop_sel,
             mem_read, mem_write, r1_sel, regw_sel, rf_write,
             r1b, r2b, alu1, alu2, alu_op, alu3, flag_write, halted
   );
endinterface

// File: rtl/pipeline_controller.sv
// Cycle-level controller for the 4-stage (F/RF/X/WB) 8-bit pipeline: hazard
// stalls, WB->RF/X forwarding, branch redirection and stop/drain/halt.
module pipeline_controller #(
   parameter logic [7:0] NOOP_IR = 8'h0A
) (
   input  logic                  clock,
   input  logic                  reset,
   pipeline_controller_if.master bus
);

   typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;
   typedef enum logic [3:0] {
      K_NOP, K_LOAD, K_STOP, K_STORE, K_ADD, K_BZ, K_SUB, K_NAND,
      K_BNZ, K_BPZ, K_ORI, K_SHIFT
   } kind_t;

   function automatic kind_t kind_of(input logic [7:0] ir);
      kind_t k;
      k = K_NOP;
      if (ir == NOOP_IR)
         k = K_NOP;
      else if (ir[2:0] == 3'b111)
         k = K_ORI;
      else if (ir[2:0] == 3'b011)
         k = K_SHIFT;
      else begin
         case (ir[3:0])
            4'b0000: k = K_LOAD;
            4'b0001: k = K_STOP;
            4'b0010: k = K_STORE;
            4'b0100: k = K_ADD;
            4'b0101: k = K_BZ;
            4'b0110: k = K_SUB;
            4'b1000: k = K_NAND;
            4'b1001: k = K_BNZ;
            4'b1101: k = K_BPZ;
            default: k = K_NOP;
         endcase
      end
      return k;
   endfunction

   function automatic logic is_writer(input kind_t k);
      return k inside {K_LOAD, K_ADD, K_SUB, K_NAND, K_ORI, K_SHIFT};
   endfunction

   function automatic logic is_flag_setter(input kind_t k);
      return k inside {K_ADD, K_SUB, K_NAND, K_ORI, K_SHIFT};
   endfunction

   function automatic logic is_branch(input kind_t k);
      return k inside {K_BZ, K_BNZ, K_BPZ};
   endfunction

   function automatic logic [2:0] alu_op_of(input kind_t k);
      logic [2:0] op;
      case (k)
         K_SUB:   op = 3'b001;
         K_NAND:  op = 3'b010;
         K_ORI:   op = 3'b011;
         K_SHIFT: op = 3'b100;
         default: op = 3'b000;
      endcase
      return op;
   endfunction

   state_t     state_reg, state_next;
   logic [3:0] v_reg, v_next, v_src;
   kind_t      d_kind, rf_kind, x_kind, wb_kind;
   logic [1:0] rf_src1, x_src1, x_dest, wb_dest;
   logic       wb_fwd, mem_stall, flag_stall, taken;

   // An invalid stage decodes as a no-op, so it can never write or hazard.
   assign d_kind  = v_reg[0] ? kind_of(bus.d_ir)  : K_NOP;
   assign rf_kind = v_reg[1] ? kind_of(bus.rf_ir) : K_NOP;
   assign x_kind  = v_reg[2] ? kind_of(bus.x_ir)  : K_NOP;
   assign wb_kind = v_reg[3] ? kind_of(bus.wb_ir) : K_NOP;

   assign rf_src1 = (rf_kind == K_ORI) ? 2'd1 : bus.rf_ir[7:6];
   assign x_src1  = (x_kind  == K_ORI) ? 2'd1 : bus.x_ir[7:6];
   assign x_dest  = (x_kind  == K_ORI) ? 2'd1 : bus.x_ir[7:6];
   assign wb_dest = (wb_kind == K_ORI) ? 2'd1 : bus.wb_ir[7:6];
   assign wb_fwd  = is_writer(wb_kind);

   assign mem_stall  = (rf_kind == K_LOAD || rf_kind == K_STORE) && is_writer(x_kind) &&
                       (x_dest == bus.rf_ir[5:4] || x_dest == bus.rf_ir[7:6]);
   assign flag_stall = is_branch(d_kind) && (is_flag_setter(rf_kind) || is_flag_setter(x_kind));
   assign taken      = (d_kind == K_BZ && bus.z) || (d_kind == K_BNZ && !bus.z) ||
                       (d_kind == K_BPZ && !bus.n);

   // Each valid bit follows its instruction; fetch always enters as valid.
   assign v_src = {v_reg[2:0], 1'b1};
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_valid
         assign v_next[gi] = bus.stage_load[gi] ? (v_src[gi] & ~bus.noop_sel[gi]) : v_reg[gi];
      end
   endgenerate

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= RUN;
         v_reg     <= '0;
      end else begin
         state_reg <= state_next;
         v_reg     <= v_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (d_kind == K_STOP) state_next = DRAIN;
         DRAIN:   if (v_next[3:1] == 3'b000) state_next = HALT;
         default: state_next = HALT;
      endcase
   end

   always_comb begin
      bus.pc_write    = 1'b0;
      bus.count_write = 1'b0;
      bus.addr_sel    = 2'd0;
      bus.stage_load  = 4'b0000;
      bus.noop_sel    = 4'b0000;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.r1_sel      = 1'b0;
      bus.regw_sel    = 1'b0;
      bus.rf_write    = 1'b0;
      bus.r1b         = 1'b0;
      bus.r2b         = 1'b0;
      bus.alu1        = 1'b0;
      bus.alu2        = 2'd0;
      bus.alu_op      = 3'b000;
      bus.alu3        = 1'b0;
      bus.flag_write  = 1'b0;
      bus.halted      = 1'b0;
      if (state_reg != HALT) begin
         bus.count_write = 1'b1;
         bus.stage_load  = 4'b1111;
         bus.addr_sel    = 2'd2;
         bus.pc_write    = (state_reg == RUN);
         bus.noop_sel[0] = (state_reg == DRAIN);
         if (mem_stall) begin
            bus.stage_load  = 4'b1100;
            bus.noop_sel[2] = 1'b1;
            bus.pc_write    = 1'b0;
         end else if (flag_stall) begin
            bus.stage_load  = 4'b1110;
            bus.noop_sel[1] = 1'b1;
            bus.pc_write    = 1'b0;
         end else begin
            if (taken) begin
               bus.addr_sel    = 2'd0;
               bus.noop_sel[0] = 1'b1;
            end
            // The slot behind a stop never executes; squashing it at once
            // leaves only stop itself to retire during DRAIN.
            if (state_reg == RUN && d_kind == K_STOP)
               bus.noop_sel[0] = 1'b1;
         end
         bus.mem_read   = (x_kind == K_LOAD);
         bus.mem_write  = (x_kind == K_STORE);
         bus.alu3       = (x_kind == K_LOAD);
         bus.flag_write = is_flag_setter(x_kind);
         bus.alu_op     = alu_op_of(x_kind);
         bus.alu1       = v_reg[2] & ~(wb_fwd && wb_dest == x_src1);
         if (x_kind == K_ORI)
            bus.alu2 = 2'd2;
         else if (x_kind == K_SHIFT)
            bus.alu2 = 2'd3;
         else if (wb_fwd && wb_dest == bus.x_ir[5:4])
            bus.alu2 = 2'd1;
         bus.r1b      = v_reg[1] & ~(wb_fwd && wb_dest == rf_src1);
         bus.r2b      = v_reg[1] & ~(wb_fwd && wb_dest == bus.rf_ir[5:4]);
         bus.r1_sel   = (rf_kind == K_ORI);
         bus.rf_write = wb_fwd;
         bus.regw_sel = wb_fwd && (wb_kind != K_ORI);
      end else begin
         bus.halted = 1'b1;
      end
   end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: a small IR-shifting datapath model
// feeds the controller while each step checks hand-computed control outputs.
module tb_pipeline_controller;
   localparam logic [7:0] NOOP = 8'h0A;
   localparam logic [27:0] RST_OUT = {1'b1, 1'b1, 2'd2, 4'hF, 4'h0, 16'h0000};
   localparam logic [27:0] HALT_OUT = 28'h0000001;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] fetch_ir;
   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;

   pipeline_controller_if bus ();

   pipeline_controller #(.NOOP_IR(NOOP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Datapath IR registers: advance on stage_load, take NOOP on noop_sel.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.d_ir  <= 8'h00;
         bus.rf_ir <= 8'h00;
         bus.x_ir  <= 8'h00;
         bus.wb_ir <= 8'h00;
      end else begin
         if (bus.stage_load[3]) bus.wb_ir <= bus.noop_sel[3] ? NOOP : bus.x_ir;
         if (bus.stage_load[2]) bus.x_ir  <= bus.noop_sel[2] ? NOOP : bus.rf_ir;
         if (bus.stage_load[1]) bus.rf_ir <= bus.noop_sel[1] ? NOOP : bus.d_ir;
         if (bus.stage_load[0]) bus.d_ir  <= bus.noop_sel[0] ? NOOP : fetch_ir;
      end
   end

   function automatic logic [27:0] all_out();
      return {bus.pc_write, bus.count_write, bus.addr_sel, bus.stage_load, bus.noop_sel,
              bus.mem_read, bus.mem_write, bus.r1_sel, bus.regw_sel, bus.rf_write,
              bus.r1b, bus.r2b, bus.alu1, bus.alu2, bus.alu_op, bus.alu3,
              bus.flag_write, bus.halted};
   endfunction

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step(input logic [7:0] f);
      fetch_ir = f;
      @(posedge clock);
      #1;
      cyc++;
      $display("[TB] cyc %0d fetch=%h d=%h rf=%h x=%h wb=%h stage_load=%b noop_sel=%b addr_sel=%0d halted=%b",
               cyc, f, bus.d_ir, bus.rf_ir, bus.x_ir, bus.wb_ir, bus.stage_load, bus.noop_sel,
               bus.addr_sel, bus.halted);
   endtask

   initial begin
      reset    = 1'b1;
      fetch_ir = NOOP;
      bus.n    = 1'b0;
      bus.z    = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset_hold_outputs", all_out(), RST_OUT);
      reset = 1'b0;
      chk("release_cycle0_outputs", all_out(), RST_OUT);

      // Reset release + forwarding: add r1,r2 then sub r3,r1
      step(8'h64);
      chk("fill1_wr_rd_fl", {bus.rf_write, bus.mem_read, bus.flag_write}, 3'b000);
      step(8'hD6);
      chk("fill2_wr_rd_fl", {bus.rf_write, bus.mem_read, bus.flag_write}, 3'b000);
      chk("fill2_r1b_r2b", {bus.r1b, bus.r2b}, 2'b11);
      step(NOOP);
      chk("fill3_add_in_x", {bus.rf_write, bus.flag_write, bus.alu_op, bus.alu1, bus.alu2}, {1'b0, 1'b1, 3'b000, 1'b1, 2'd0});
      step(NOOP);
      chk("fill4_add_in_wb", {bus.rf_write, bus.regw_sel}, 2'b11);
      chk("fwd_sub_alu1_alu2", {bus.alu1, bus.alu2}, {1'b1, 2'd1});
      chk("fwd_sub_op_nostall", {bus.alu_op, bus.stage_load, bus.pc_write}, {3'b001, 4'hF, 1'b1});
      step(NOOP);
      step(NOOP);

      // Branch: sub r0,r0 then bz +3 -> two flag stalls, then taken
      step(8'h06);
      step(8'h35);
      chk("flag_stall1", {bus.stage_load, bus.noop_sel, bus.pc_write}, {4'b1110, 4'b0010, 1'b0});
      step(NOOP);
      chk("flag_stall2", {bus.stage_load, bus.noop_sel, bus.pc_write}, {4'b1110, 4'b0010, 1'b0});
      chk("flag_stall2_flag_write", bus.flag_write, 1'b1);
      bus.z = 1'b1;
      step(NOOP);
      chk("bz_taken", {bus.addr_sel, bus.noop_sel, bus.stage_load, bus.pc_write}, {2'd0, 4'b0001, 4'hF, 1'b1});
      bus.z = 1'b0;
      step(NOOP);
      step(8'h35);
      chk("bz_not_taken", {bus.addr_sel, bus.noop_sel, bus.pc_write}, {2'd2, 4'b0000, 1'b1});
      step(8'h39);
      chk("bnz_taken", {bus.addr_sel, bus.noop_sel}, {2'd0, 4'b0001});
      bus.n = 1'b1;
      step(NOOP);
      step(8'h3D);
      chk("bpz_not_taken", {bus.addr_sel, bus.noop_sel}, {2'd2, 4'b0000});
      bus.n = 1'b0;
      step(NOOP);
      step(NOOP);
      step(NOOP);

      // Mem stall (with a flag-stalled bz behind it): add r2,r3; load r0,(r2); bz
      step(8'hB4);
      step(8'h20);
      step(8'h35);
      chk("mem_stall_priority", {bus.stage_load, bus.noop_sel, bus.pc_write}, {4'b1100, 4'b0100, 1'b0});
      chk("mem_stall_flag_write", bus.flag_write, 1'b1);
      step(NOOP);
      chk("after_mem_stall", {bus.stage_load, bus.addr_sel, bus.noop_sel}, {4'hF, 2'd2, 4'b0000});
      chk("load_rf_fwd_r1b_r2b", {bus.r1b, bus.r2b, bus.rf_write}, 3'b101);
      step(NOOP);
      chk("load_in_x", {bus.mem_read, bus.mem_write, bus.alu3}, 3'b101);
      step(NOOP);
      step(NOOP);

      // Stop after an add: DRAIN for three cycles, then HALT
      step(8'h64);
      step(8'h01);
      chk("stop_in_d_run", {bus.pc_write, bus.count_write, bus.halted}, 3'b110);
      step(NOOP);
      chk("drain1", {bus.pc_write, bus.noop_sel, bus.count_write, bus.flag_write, bus.halted}, {1'b0, 4'b0001, 1'b1, 1'b1, 1'b0});
      step(NOOP);
      chk("drain2", {bus.pc_write, bus.rf_write, bus.halted}, 3'b010);
      step(NOOP);
      chk("drain3", {bus.pc_write, bus.count_write, bus.halted}, 3'b010);
      step(NOOP);
      chk("halt_outputs", all_out(), HALT_OUT);
      step(NOOP);
      chk("halt_persists", all_out(), HALT_OUT);

      #2;
      reset = 1'b1;
      #1;
      chk("async_reset_from_halt", all_out(), RST_OUT);
      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
